// File: rtl/pkt_symbol_packer.sv
// pkt_symbol_packer
// Narrow-to-wide packet packer: gathers BITS_PER_SYMBOL symbols into
// SYMBOL_PER_BEATS-wide beats (slot 0 in the MSBs) with an Avalon-ST style
// empty count. It drops or re-frames malformed input on the way in, so the
// downstream packet FIFO only ever sees well-formed packets.
// Optional feature: define PKT_SYMBOL_PACKER_ERR_CNT_EN to add a saturating
// 32-bit framing-error counter on port err_cnt.
module pkt_symbol_packer #(
   parameter int BITS_PER_SYMBOL  = 20,
   parameter int SYMBOL_PER_BEATS = 4,
   localparam int EMPTY_W = (SYMBOL_PER_BEATS > 1) ? $clog2(SYMBOL_PER_BEATS) : 1
) (
`ifdef PKT_SYMBOL_PACKER_ERR_CNT_EN
   output logic [31:0]                                 err_cnt,
`endif
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic [BITS_PER_SYMBOL-1:0]                  in_data,
   input  logic                                        in_sop,
   input  logic                                        in_eop,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [BITS_PER_SYMBOL*SYMBOL_PER_BEATS-1:0] out_data,
   output logic                                        out_sop,
   output logic                                        out_eop,
   output logic [EMPTY_W-1:0]                          out_empty
);

   localparam int DATA_W = BITS_PER_SYMBOL * SYMBOL_PER_BEATS;
   localparam int CNT_W  = $clog2(SYMBOL_PER_BEATS) + 1;
   localparam logic [EMPTY_W-1:0] LAST_SLOT_E = EMPTY_W'(SYMBOL_PER_BEATS - 1);
   localparam logic [CNT_W-1:0]   LAST_SLOT_C = CNT_W'(SYMBOL_PER_BEATS - 1);

   typedef enum logic {ST_IDLE, ST_IN_PKT} state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_first;
   logic [DATA_W-1:0]   r_acc;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_out_sop;
   logic                r_out_eop;
   logic [EMPTY_W-1:0]  r_out_empty;

   logic                w_in_fire;
   logic                w_out_fire;
   logic                w_accept;
   logic                w_complete;
   logic [CNT_W-1:0]    w_slot;
   logic [DATA_W-1:0]   w_merged;
   logic [EMPTY_W-1:0]  w_empty;

   // Single output register: a new symbol may enter whenever that register is
   // free or is being drained this cycle. Framing bits never gate in_ready.
   assign in_ready   = !r_out_valid || out_ready;
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = r_out_valid && out_ready;

   // Symbols without sop are only meaningful inside a packet; in IDLE they are dropped.
   assign w_accept   = w_in_fire && (in_sop || (r_state == ST_IN_PKT));

   // Merge the incoming symbol into the accumulator at its slot; an sop restarts at slot 0.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
      w_slot   = in_sop ? '0 : r_cnt;
      w_merged = in_sop ? '0 : r_acc;
      for (int k = 0; k < SYMBOL_PER_BEATS; k++) begin
         if (w_slot == CNT_W'(k))
            w_merged[(SYMBOL_PER_BEATS-k)*BITS_PER_SYMBOL-1 -: BITS_PER_SYMBOL] = in_data;
      end
      w_complete = w_accept && (in_eop || (w_slot == LAST_SLOT_C));
      w_empty    = in_eop ? (LAST_SLOT_E - w_slot[EMPTY_W-1:0]) : '0;
   end

   // Framing FSM, accumulator and registered output beat.
   always_ff @(posedge clk) begin
      // NOTE: the accumulator is an ordinary register, not a memory, so it is reset with the rest of the state.
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_first     <= 1'b0;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sop   <= 1'b0;
         r_out_eop   <= 1'b0;
         r_out_empty <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout; a later completion overrides the drain below.
         if (w_out_fire)
            r_out_valid <= 1'b0;
         if (w_accept) begin
            if (w_complete) begin
               r_out_valid <= 1'b1;
               r_out_data  <= w_merged;
               r_out_sop   <= in_sop || r_first;
               r_out_eop   <= in_eop;
               r_out_empty <= w_empty;
               r_first     <= 1'b0;
               r_cnt       <= '0;
               r_acc       <= '0;
               r_state     <= in_eop ? ST_IDLE : ST_IN_PKT;
            end else begin
               r_acc       <= w_merged;
               r_cnt       <= w_slot + CNT_W'(1);
               r_first     <= in_sop || r_first;
               r_state     <= ST_IN_PKT;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sop   = r_out_sop;
   assign out_eop   = r_out_eop;
   assign out_empty = r_out_empty;

`ifdef PKT_SYMBOL_PACKER_ERR_CNT_EN
   logic        w_err;
   logic [31:0] r_err_cnt;

   // A framing error is data without sop in IDLE, or a fresh sop inside a packet.
   assign w_err = w_in_fire && ((r_state == ST_IDLE) ? !in_sop : in_sop);

   // Saturating framing-error counter.
   always_ff @(posedge clk) begin
      if (rst)
         r_err_cnt <= '0;
      else if (w_err && (r_err_cnt != 32'hFFFF_FFFF))
         r_err_cnt <= r_err_cnt + 32'd1;
   end

   assign err_cnt = r_err_cnt;
`endif

endmodule
